// File: rtl/au_host_pkg.sv
// Shared definitions for the arithmetic-unit host sequencer: op codes, FSM states,
// control/feedback pin bit positions and small helpers.
package au_host_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        OP_RUN,
        OP_DROP,
        RD_SEL,
        RD_CAP,
        RESP
    } state_t;

    // ctl_out (unit uio_in) bit positions; CTL_OP and CTL_REG are 2-bit field LSBs
    localparam int CTL_C   = 7;
    localparam int CTL_OP  = 5;
    localparam int CTL_REG = 3;
    localparam int CTL_RW  = 2;
    localparam int CTL_S   = 1;

    // fb_in (unit uio_out) bit positions
    localparam int FB_P   = 5;
    localparam int FB_N   = 4;
    localparam int FB_F   = 3;
    localparam int FB_ERR = 0;

    function automatic logic [7:0] ctl_word(input logic c, input logic [1:0] op,
                                            input logic [1:0] idx, input logic rw,
                                            input logic s);
        logic [7:0] w;
        w = '0;
        w[CTL_C]        = c;
        w[CTL_OP+:2]    = op;
        w[CTL_REG+:2]   = idx;
        w[CTL_RW]       = rw;
        w[CTL_S]        = s;
        return w;
    endfunction

    function automatic int max3(input int p, input int q, input int r);
        int m;
        m = p;
        if (q > m) m = q;
        if (r > m) m = r;
        return m;
    endfunction

endpackage

// File: rtl/au_host_sequencer_timer.sv
// Loadable down-counter with a zero flag; times every SETTLE, ADD_WAIT and TIMEOUT
// interval of the host sequencer.
module au_host_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/au_host_sequencer.sv
// Host-side pin-protocol initiator for the 16-bit arithmetic unit: writes A/B, runs one
// operation, reads both registers back. Optional MUL abort: define AU_HOST_TIMEOUT_EN.
module au_host_sequencer
    import au_host_pkg::*;
#(
    parameter int SETTLE   = 2,
    parameter int ADD_WAIT = 24,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_signed,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [7:0]  cmd_x,
    output logic [7:0]  ui_out,
    output logic [7:0]  ctl_out,
    input  logic [7:0]  uo_in,
    input  logic [7:0]  fb_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_a,
    output logic [15:0] rsp_b,
    output logic        rsp_p,
    output logic        rsp_n,
    output logic        rsp_err,
    output logic        rsp_timeout
);

    localparam int TW = $clog2(max3(SETTLE, ADD_WAIT, TIMEOUT) + 1);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE - 1);
    localparam logic [TW-1:0] T_ADD    = TW'(ADD_WAIT - 1);
`ifdef AU_HOST_TIMEOUT_EN
    localparam logic [TW-1:0] T_MUL    = TW'(TIMEOUT - 1);
`else
    localparam logic [TW-1:0] T_MUL    = '0;
`endif

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  x;
    logic        f_seen;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_done;
    logic          accept;
    logic          f_hit;
    logic          tmo_hit;
    logic          run_exit;
    logic          unused_fb;

    assign unused_fb = ^{fb_in[7:6], fb_in[2:1]};

    function automatic logic [7:0] wr_byte(input logic [1:0] i, input logic [15:0] ra,
                                           input logic [15:0] rb);
        case (i)
            2'd0:    return ra[7:0];
            2'd1:    return ra[15:8];
            2'd2:    return rb[7:0];
            default: return rb[15:8];
        endcase
    endfunction

    au_host_cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (RST),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    // Timer reload follows the FSM's phase exits; every exit reloads for the phase entered.
    always_comb begin
        accept   = (state == IDLE) && cmd_valid && cmd_ready;
        f_hit    = (state == OP_RUN) && (op == OP_MUL) && !f_seen && fb_in[FB_F];
`ifdef AU_HOST_TIMEOUT_EN
        tmo_hit  = (state == OP_RUN) && (op == OP_MUL) && !f_seen && !fb_in[FB_F] && tmr_done;
`else
        tmo_hit  = 1'b0;
`endif
        run_exit = (state == OP_RUN) && tmr_done && ((op != OP_MUL) || f_seen);
        tmr_load  = 1'b0;
        tmr_value = T_SETTLE;
        case (state)
            IDLE:      tmr_load = accept;
            WR_SETUP:  tmr_load = tmr_done;
            WR_STROBE: begin
                tmr_load  = tmr_done;
                tmr_value = '0;
            end
            WR_HOLD: begin
                tmr_load = 1'b1;
                if (idx == 2'd3 && op != OP_LOAD)
                    tmr_value = (op == OP_MUL) ? T_MUL : T_ADD;
            end
            OP_RUN:    tmr_load = f_hit || tmo_hit || run_exit;
            OP_DROP:   tmr_load = tmr_done;
            RD_SEL: begin
                tmr_load  = tmr_done;
                tmr_value = '0;
            end
            RD_CAP:    tmr_load = 1'b1;
            default:   tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            op        <= OP_LOAD;
            sgn       <= 1'b0;
            a         <= '0;
            b         <= '0;
            x         <= '0;
            f_seen    <= 1'b0;
            cmd_ready <= 1'b1;
            ui_out    <= '0;
            ctl_out   <= '0;
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            rsp_p     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef AU_HOST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            if (state != IDLE && state != RESP)
                rsp_err <= rsp_err | fb_in[FB_ERR];
            case (state)
                IDLE: begin
                    if (accept) begin
                        op        <= cmd_op;
                        sgn       <= cmd_signed;
                        a         <= cmd_a;
                        b         <= cmd_b;
                        x         <= cmd_x;
                        idx       <= 2'd0;
                        f_seen    <= 1'b0;
                        cmd_ready <= 1'b0;
                        rsp_a     <= '0;
                        rsp_b     <= '0;
                        rsp_p     <= 1'b0;
                        rsp_n     <= 1'b0;
                        rsp_err   <= fb_in[FB_ERR];
`ifdef AU_HOST_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        ctl_out   <= ctl_word(1'b0, OP_LOAD, 2'd0, 1'b1, 1'b0);
                        ui_out    <= cmd_a[7:0];
                        state     <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (tmr_done) begin
                        ctl_out[CTL_S] <= 1'b1;
                        state          <= WR_STROBE;
                    end
                end
                WR_STROBE: begin
                    if (tmr_done) begin
                        ctl_out[CTL_S] <= 1'b0;
                        state          <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    if (idx != 2'd3) begin
                        idx     <= idx + 2'd1;
                        ctl_out <= ctl_word(1'b0, OP_LOAD, idx + 2'd1, 1'b1, 1'b0);
                        ui_out  <= wr_byte(idx + 2'd1, a, b);
                        state   <= WR_SETUP;
                    end else if (op == OP_LOAD) begin
                        idx     <= 2'd0;
                        ctl_out <= ctl_word(1'b0, OP_LOAD, 2'd0, 1'b0, 1'b0);
                        ui_out  <= '0;
                        state   <= RD_SEL;
                    end else begin
                        ctl_out <= ctl_word(sgn, op, 2'd0, 1'b1, 1'b1);
                        ui_out  <= x;
                        state   <= OP_RUN;
                    end
                end
                OP_RUN: begin
                    if (f_hit)
                        f_seen <= 1'b1;
                    if (tmo_hit || run_exit) begin
                        rsp_p          <= fb_in[FB_P];
                        rsp_n          <= fb_in[FB_N];
`ifdef AU_HOST_TIMEOUT_EN
                        rsp_timeout    <= tmo_hit;
`endif
                        ctl_out[CTL_S] <= 1'b0;
                        state          <= OP_DROP;
                    end
                end
                OP_DROP: begin
                    if (tmr_done) begin
                        idx     <= 2'd0;
                        ctl_out <= ctl_word(1'b0, OP_LOAD, 2'd0, 1'b0, 1'b0);
                        ui_out  <= '0;
                        state   <= RD_SEL;
                    end
                end
                RD_SEL: begin
                    if (tmr_done)
                        state <= RD_CAP;
                end
                RD_CAP: begin
                    case (idx)
                        2'd0:    rsp_a[7:0]  <= uo_in;
                        2'd1:    rsp_a[15:8] <= uo_in;
                        2'd2:    rsp_b[7:0]  <= uo_in;
                        default: rsp_b[15:8] <= uo_in;
                    endcase
                    if (idx != 2'd3) begin
                        idx     <= idx + 2'd1;
                        ctl_out <= ctl_word(1'b0, OP_LOAD, idx + 2'd1, 1'b0, 1'b0);
                        state   <= RD_SEL;
                    end else begin
                        ctl_out   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef AU_HOST_TIMEOUT_EN
    assign rsp_timeout = 1'b0;
`endif

endmodule
